// File: rtl/compressor_param_sequencer.sv
// Threshold/ratio sequencer for the compressor: slews point toward each requested
// target by STEP per sample, then commits the clamped rate. Optional ramp counter: COMP_SEQ_RAMP_CNT_EN.

// state  | meaning
// IDLE   | no request pending; point and rate stable
// RAMP   | point stepping toward target on each sample_en
// SETTLE | point at target; rate commits on next sample_en
module compressor_param_sequencer #(
    parameter int DATA_W   = 32,
    parameter int STEP     = 16,
    parameter int RATE_MAX = 16
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     sample_en,
    input  logic                     cfg_valid,
    output logic                     cfg_ready,
    input  logic signed [DATA_W-1:0] cfg_point,
    input  logic signed [DATA_W-1:0] cfg_rate,
    output logic signed [DATA_W-1:0] point,
    output logic signed [DATA_W-1:0] rate,
    output logic                     busy
`ifdef COMP_SEQ_RAMP_CNT_EN
    ,
    output logic [15:0]              ramp_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RAMP   = 2'd1,
        SETTLE = 2'd2
    } state_t;

    localparam logic signed [DATA_W:0]   STEP_X     = (DATA_W+1)'(STEP);
    localparam logic signed [DATA_W-1:0] STEP_W     = DATA_W'(STEP);
    localparam logic signed [DATA_W-1:0] RATE_MAX_W = DATA_W'(RATE_MAX);

    state_t                     state_q, state_d;
    logic signed [DATA_W-1:0]   point_q, point_d;
    logic signed [DATA_W-1:0]   rate_q, rate_d;
    logic signed [DATA_W-1:0]   target_q, target_d;
    logic signed [DATA_W-1:0]   pend_rate_q, pend_rate_d;
    logic                       cfg_ready_q, cfg_ready_d;
    logic                       busy_q, busy_d;
    logic                       accept;
    logic signed [DATA_W:0]     diff;
    logic signed [DATA_W:0]     diff_abs;
    logic signed [DATA_W-1:0]   rate_clamped;

    always_comb begin
        accept = cfg_valid && cfg_ready_q;

        // Extra bit keeps target - point exact for any pair of DATA_W values.
        diff     = {target_q[DATA_W-1], target_q} - {point_q[DATA_W-1], point_q};
        diff_abs = diff[DATA_W] ? -diff : diff;

        if (cfg_rate[DATA_W-1]) begin
            rate_clamped = '0;
        end else if (cfg_rate > RATE_MAX_W) begin
            rate_clamped = RATE_MAX_W;
        end else begin
            rate_clamped = cfg_rate;
        end
    end

    always_comb begin
        state_d     = state_q;
        point_d     = point_q;
        rate_d      = rate_q;
        target_d    = target_q;
        pend_rate_d = pend_rate_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    target_d    = cfg_point;
                    pend_rate_d = rate_clamped;
                    state_d     = (cfg_point != point_q) ? RAMP : SETTLE;
                end
            end
            RAMP: begin
                if (sample_en) begin
                    if (diff_abs <= STEP_X) begin
                        point_d = target_q;
                        state_d = SETTLE;
                    end else if (!diff[DATA_W]) begin
                        point_d = point_q + STEP_W;
                    end else begin
                        point_d = point_q - STEP_W;
                    end
                end
                // A retarget keeps ramping even if this sample snapped to the old target.
                if (accept) begin
                    target_d    = cfg_point;
                    pend_rate_d = rate_clamped;
                    state_d     = RAMP;
                end
            end
            SETTLE: begin
                if (sample_en) begin
                    rate_d  = pend_rate_q;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        cfg_ready_d = (state_d != SETTLE);
        busy_d      = (state_d != IDLE);
    end

`ifdef COMP_SEQ_RAMP_CNT_EN
    logic [15:0] ramp_cnt_q, ramp_cnt_d;

    always_comb begin
        ramp_cnt_d = ramp_cnt_q;
        if (accept) begin
            ramp_cnt_d = '0;
        end else if (state_q == RAMP && sample_en && ramp_cnt_q != 16'hFFFF) begin
            ramp_cnt_d = ramp_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ramp_cnt_q <= '0;
        end else begin
            ramp_cnt_q <= ramp_cnt_d;
        end
    end

    assign ramp_cnt = ramp_cnt_q;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            point_q     <= '0;
            rate_q      <= '0;
            target_q    <= '0;
            pend_rate_q <= '0;
            cfg_ready_q <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            point_q     <= point_d;
            rate_q      <= rate_d;
            target_q    <= target_d;
            pend_rate_q <= pend_rate_d;
            cfg_ready_q <= cfg_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign point     = point_q;
    assign rate      = rate_q;
    assign cfg_ready = cfg_ready_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_compressor_param_sequencer.sv
// Scoreboard bench for compressor_param_sequencer: every point/rate change is popped
// against a hand-computed expected sequence. Build with COMP_SEQ_RAMP_CNT_EN to cover ramp_cnt.
module tb_compressor_param_sequencer;

    localparam int DW = 32;

    logic                 CLK = 1'b0;
    logic                 RST;
    logic                 sample_en;
    logic                 cfg_valid;
    logic                 cfg_ready;
    logic signed [DW-1:0] cfg_point;
    logic signed [DW-1:0] cfg_rate;
    logic signed [DW-1:0] point;
    logic signed [DW-1:0] rate;
    logic                 busy;
`ifdef COMP_SEQ_RAMP_CNT_EN
    logic [15:0]          ramp_cnt;
`endif

    compressor_param_sequencer #(
        .DATA_W   (DW),
        .STEP     (16),
        .RATE_MAX (16)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .sample_en (sample_en),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_point (cfg_point),
        .cfg_rate  (cfg_rate),
        .point     (point),
        .rate      (rate),
        .busy      (busy)
`ifdef COMP_SEQ_RAMP_CNT_EN
        ,
        .ramp_cnt  (ramp_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic signed [31:0] p;
        logic signed [31:0] r;
        logic               b;
    } exp_t;

    exp_t                 exp_q[$];
    int                   tests = 0;
    int                   fails = 0;
    int                   cyc = 0;
    bit                   saw_rate3 = 1'b0;
    bit                   primed = 1'b0;
    logic signed [DW-1:0] prev_p;
    logic signed [DW-1:0] prev_r;

    task automatic chk(input string name, input longint act, input longint req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic push(input int p, input int r, input bit b);
        exp_t e;
        e.p = p;
        e.r = r;
        e.b = b;
        exp_q.push_back(e);
    endtask

    // Called just after a negedge; returns one negedge after the accepting posedge.
    task automatic send(input int p, input int r);
        int n;
        cfg_point = p;
        cfg_rate  = r;
        cfg_valid = 1'b1;
        n = 0;
        while (!cfg_ready && n < 200) begin
            @(negedge CLK);
            n++;
        end
        chk("send_ready_seen", (n < 200) ? 1 : 0, 1);
        @(negedge CLK);
        cfg_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 500) begin
            @(negedge CLK);
            n++;
        end
        chk("wait_idle", busy, 0);
    endtask

    task automatic wait_point(input int v);
        int n;
        n = 0;
        while (point != v && n < 500) begin
            @(negedge CLK);
            n++;
        end
        chk("wait_point", point, v);
    endtask

    initial begin
        sample_en = 1'b0;
        forever begin
            @(negedge CLK);
            cyc++;
            sample_en = (cyc % 4 == 0);
        end
    end

    // Monitor: any change of point or rate is an output event to score.
    initial begin
        bit   se;
        bit   rs;
        exp_t e;
        forever begin
            @(posedge CLK);
            se = sample_en;
            rs = RST;
            #1;
            if (!primed) begin
                prev_p = point;
                prev_r = rate;
                primed = 1'b1;
            end else if (point != prev_p || rate != prev_r) begin
                if (rate == 3) saw_rate3 = 1'b1;
                chk("change_on_strobe", (se || rs) ? 1 : 0, 1);
                if (exp_q.size() == 0) begin
                    chk("unexpected_change_point", point, prev_p);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_point", point, e.p);
                    chk("sb_rate", rate, e.r);
                    chk("sb_busy", busy, e.b);
                end
                prev_p = point;
                prev_r = rate;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int bad;
        RST       = 1'b1;
        cfg_valid = 1'b1;
        cfg_point = 55;
        cfg_rate  = 9;
        repeat (5) @(negedge CLK);
        chk("reset_point", point, 0);
        chk("reset_rate", rate, 0);
        chk("reset_busy", busy, 0);
        chk("reset_ready", cfg_ready, 1);
        RST       = 1'b0;
        cfg_valid = 1'b0;
        repeat (3) @(negedge CLK);
        chk("reset_no_accept_busy", busy, 0);
        chk("reset_no_accept_point", point, 0);

        // upward ramp
        for (int i = 1; i <= 6; i++) push(16 * i, 0, 1);
        push(100, 0, 1);
        push(100, 4, 0);
        send(100, 4);
        wait_idle();
`ifdef COMP_SEQ_RAMP_CNT_EN
        chk("ramp_cnt_up", ramp_cnt, 7);
`endif

        // downward through zero
        push(84, 4, 1);  push(68, 4, 1);  push(52, 4, 1);
        push(36, 4, 1);  push(20, 4, 1);  push(4, 4, 1);
        push(-12, 4, 1); push(-28, 4, 1); push(-40, 4, 1);
        push(-40, 2, 0);
        send(-40, 2);
        wait_idle();
`ifdef COMP_SEQ_RAMP_CNT_EN
        chk("ramp_cnt_down", ramp_cnt, 9);
`endif

        // back to 0, then retarget mid-ramp
        push(-24, 2, 1); push(-8, 2, 1); push(0, 2, 1); push(0, 1, 0);
        send(0, 1);
        wait_idle();
        push(16, 1, 1); push(32, 1, 1); push(48, 1, 1);
        send(1000, 3);
        wait_point(48);
        push(32, 1, 1); push(16, 1, 1); push(0, 1, 1); push(0, 2, 0);
        send(0, 2);
        wait_idle();

        // clamp high/low with equal target
        push(0, 16, 0);
        send(0, 100);
        chk("equal_target_busy", busy, 1);
        wait_idle();
        push(0, 0, 0);
        send(0, -3);
        wait_idle();

        // ready stall through SETTLE
        push(16, 0, 1); push(32, 0, 1); push(48, 0, 1); push(64, 0, 1); push(64, 5, 0);
        send(64, 5);
        n = 0;
        while (!(busy && !cfg_ready) && n < 500) begin
            @(negedge CLK);
            n++;
        end
        chk("settle_reached", cfg_ready, 0);
        push(48, 5, 1); push(32, 5, 1); push(16, 5, 1); push(0, 5, 1);
        push(-16, 5, 1); push(-16, 16, 0);
        cfg_point = -16;
        cfg_rate  = 20;
        cfg_valid = 1'b1;
        n   = 0;
        bad = 0;
        while (busy && n < 100) begin
            if (cfg_ready) bad++;
            @(negedge CLK);
            n++;
        end
        chk("stall_ready_low", bad, 0);
        chk("stall_idle_ready", cfg_ready, 1);
        @(negedge CLK);
        cfg_valid = 1'b0;
        chk("stall_accept_busy", busy, 1);
`ifdef COMP_SEQ_RAMP_CNT_EN
        chk("ramp_cnt_clear", ramp_cnt, 0);
`endif
        wait_idle();

        // reset mid-ramp
        push(0, 16, 1); push(16, 16, 1); push(32, 16, 1); push(48, 16, 1);
        send(100, 7);
        wait_point(48);
        push(0, 0, 0);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        chk("midrst_point", point, 0);
        chk("midrst_rate", rate, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_ready", cfg_ready, 1);
        repeat (12) @(negedge CLK);
        chk("postrst_point", point, 0);
        chk("postrst_rate", rate, 0);
        chk("postrst_busy", busy, 0);

        repeat (4) @(negedge CLK);
        chk("queue_drained", exp_q.size(), 0);
        chk("rate_never_3", saw_rate3, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/compressor_param_sequencer.md
Name: compressor_param_sequencer

Overview:
- Control-side block driving the point (threshold) and rate (ratio) inputs of the audio compressor datapath.
- Accepts configuration requests over a valid/ready port.
- Ramps point toward the requested value by a fixed step per sample so the threshold never jumps.
- Commits the new rate only after point has settled, on a sample boundary.

Parameters:
- DATA_W, 32: width of point and cfg_point (signed) and of rate and cfg_rate (signed).
- STEP, 16: maximum change in point per sample_en; positive.
- RATE_MAX, 16: upper clamp applied to the committed rate.

Ports:
- CLK, input, 1: clock, rising edge.
- RST, input, 1: reset, synchronous and active-high.
- sample_en, input, 1: one-cycle strobe marking each audio sample boundary.
- cfg_valid, input, 1: configuration request valid.
- cfg_ready, output, 1: configuration request accepted when cfg_valid and cfg_ready are both high.
- cfg_point, input, DATA_W: target threshold, signed.
- cfg_rate, input, DATA_W: target ratio, signed.
- point, output, DATA_W: threshold to the compressor, signed, registered.
- rate, output, DATA_W: ratio to the compressor, signed, registered.
- busy, output, 1: high whenever state is not IDLE.

Behaviour:
- Clock and reset: one clock, CLK. RST is synchronous and active-high.
- Reset values: point=0, rate=0, target=0, pend_rate=0, state=IDLE, cfg_ready=1, busy=0. RST asserted mid-ramp or mid-settle discards any pending request and restores these values on the next edge.
- States:
  - IDLE: cfg_ready=1.
  - RAMP: cfg_ready=1.
  - SETTLE: cfg_ready=0.
- Accept (cfg_valid & cfg_ready):
  - Latch target <= cfg_point.
  - Latch pend_rate <= clamp(cfg_rate, 0, RATE_MAX): negative values become 0, values above RATE_MAX become RATE_MAX.
  - Next state is RAMP if cfg_point != point, otherwise SETTLE.
- IDLE: sample_en has no effect.
  - Accept in the same cycle as sample_en: no step is taken that cycle; the ramp starts on the next sample_en.
- RAMP, on sample_en:
  - diff = target - point, computed at DATA_W+1 bits so it cannot overflow.
  - If |diff| <= STEP: point <= target and state -> SETTLE.
  - Else if diff > 0: point <= point + STEP. Else: point <= point - STEP.
  - Without sample_en, point holds.
- Retarget during RAMP:
  - Accept overwrites target and pend_rate; state stays RAMP.
  - If the accept coincides with sample_en, that cycle's step uses the old target; the new target applies from the next sample_en.
  - The equal-target shortcut does not apply in RAMP; the next sample_en snaps point (diff=0) and moves to SETTLE.
- SETTLE, on the next sample_en: rate <= pend_rate and state -> IDLE.
- Output timing:
  - point and rate change only on edges where sample_en=1.
  - rate never changes while point is still ramping.
- busy follows state; it is deasserted on the edge that enters IDLE.
- A cfg_valid held through SETTLE is accepted in the first IDLE cycle.

Optional Feature:
- Macro: COMP_SEQ_RAMP_CNT_EN.
- Defined:
  - Adds output ramp_cnt [15:0].
  - Cleared to 0 on reset and on every accept.
  - Increments on each sample_en while in RAMP; saturates at 0xFFFF.
  - Holds its value in SETTLE and IDLE.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan (STEP=16, RATE_MAX=16, sample_en every 4th cycle):
- Reset: RST=1 for 5 cycles with cfg_valid=1 -> point=0, rate=0, busy=0, cfg_ready=1, no request accepted.
- Upward ramp: from reset, accept point=100, rate=4.
  - point steps 16,32,48,64,80,96,100 on successive sample_en.
  - rate stays 0 until the following sample_en, then becomes 4; busy falls on that edge.
  - With macro: ramp_cnt=7.
- Downward and negative: from point=100, accept point=-40, rate=2.
  - point steps 84,68,52,36,20,4,-12,-28,-40 (9 samples).
  - rate becomes 2 one sample later.
- Retarget: from 0, accept 1000/rate=3; after point reaches 48, accept 0/rate=2.
  - point steps 32,16,0, then rate=2.
  - rate never takes the value 3.
- Clamp, equal target, ready stall:
  - Accept rate=100 with point unchanged -> SETTLE immediately; rate=16 at the next sample_en.
  - Accept rate=-3 -> rate=0.
  - cfg_valid held during SETTLE: cfg_ready=0 throughout; the request is accepted in the first IDLE cycle.
- Reset mid-ramp: RST for 1 cycle while point=48 and state=RAMP.
  - point=0, rate=0, busy=0.
  - Subsequent sample_en leave point and rate unchanged.
